return_addr_stack: RTL
======================

Name: return_addr_stack

Overview:
- Hardware return-address stack that services the StackWr/StackRd strobes issued by the processor control unit.
- CALL-type instructions push the return address; RET / stop-bit terminated instructions pop it.
- Sits beside the PC logic: top_data feeds the PC-source mux input selected when PCSrc chooses "return address".
- Tracks occupancy and raises sticky overflow/underflow errors for debug and trap logic.

Parameters:
DATA_W, 32, width of one stored return address
DEPTH, 8, number of entries (power of two, >= 2)
CNT_W, $clog2(DEPTH)+1, width of occupancy counter (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
StackWr  in  1  push strobe from control unit
StackRd  in  1  pop strobe from control unit
push_data  in  DATA_W  return address to push (PC+1 from fetch)
err_clr  in  1  synchronous clear of sticky error flags
top_data  out  DATA_W  current top-of-stack entry, combinational from storage
empty  out  1  count == 0
full  out  1  count == DEPTH
count  out  CNT_W  current occupancy
overflow_err  out  1  sticky: push attempted while full
underflow_err  out  1  sticky: pop attempted while empty

Behaviour:
- Reset (async, any time, including mid push/pop): count=0, empty=1, full=0, overflow_err=0, underflow_err=0, top_data=0. Storage contents are don't-care and are never visible.
- Storage: DEPTH x DATA_W register array, pointer sp = count. Top entry is mem[count-1].
- top_data: combinational, zero latency. Equals mem[count-1] when !empty, else 0. Lets the PC mux consume the return address in the same cycle StackRd is asserted.
- Push only (StackWr=1, StackRd=0), not full: at the edge, mem[count] <= push_data and count <= count+1. The new value appears on top_data the next cycle.
- Push only while full: no storage or count change; overflow_err <= 1.
- Pop only (StackRd=1, StackWr=0), not empty: count <= count-1. The data consumed is the top_data value in that same cycle.
- Pop only while empty: no change; underflow_err <= 1.
- Simultaneous push+pop, not empty: replace top. mem[count-1] <= push_data; count unchanged; no error, even when full.
- Simultaneous push+pop while empty: treated as a push. mem[0] <= push_data, count <= 1; no underflow flagged.
- No wrap-around: the stack never overwrites the oldest entry.
- Error flags are sticky until reset or err_clr. If err_clr and a new error event fall in the same cycle, the new event wins (flag = 1).
- No internal FSM beyond the count register. The state space is EMPTY / PARTIAL / FULL, derived from count.
  - EMPTY -> PARTIAL on push.
  - PARTIAL -> FULL when a push makes count == DEPTH.
  - FULL -> PARTIAL on pop.
  - PARTIAL -> EMPTY when a pop makes count == 0.
- All outputs except top_data are registered or derived directly from registered count.

Decomposition:
- Shared package riscp_pkg holds:
  - DATA_W default
  - RAS_DEPTH default
  - the PCSrc encoding constant PCSRC_RET (2'b11) so the PC mux and control unit agree on which mux input top_data drives.
- One natural sub-module: ras_regfile, the DEPTH x DATA_W array.
  - One synchronous write port (addr, data, we).
  - One combinational read port.
  - Pointer/count/flag logic stays in return_addr_stack.

Test Plan:
- Reset, then push 0x00000010, 0x00000020, 0x00000030 -> count=3, top_data=0x30; then 3 pops -> top_data reads 0x30, 0x20, 0x10 in the pop cycles, ending empty=1, top_data=0.
- Push 8 values (DEPTH=8) -> full=1, count=8; 9th push of 0xDEAD -> overflow_err=1, count stays 8, top_data unchanged; pop -> full=0, top = 8th value.
- Pop from empty after reset -> underflow_err=1, count=0; assert err_clr one cycle -> flag returns to 0.
- Push 0x100, then push+pop together with push_data 0x200 -> count=1, top_data=0x200. Push+pop together while empty with 0x300 -> count=1, top_data=0x300, no underflow.
- Fill 5 entries, assert reset asynchronously mid-cycle between edges -> count=0, empty=1, flags=0, top_data=0 immediately, without waiting for a clock edge.
- Overflow event and err_clr in the same cycle -> overflow_err=1 after the edge.

Source files
------------

// File: rtl/riscp_pkg.sv
// riscp_pkg: shared defaults for the return-address stack and the PC-source encoding it feeds.
package riscp_pkg;
  localparam int RAS_DATA_W = 32;
  localparam int RAS_DEPTH = 8;
  localparam logic [1:0] PCSRC_RET = 2'b11;
endpackage

// File: rtl/return_addr_stack_if.sv
// return_addr_stack_if: control-unit side strobes and stack status outputs.
interface return_addr_stack_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
);
  logic StackWr;
  logic StackRd;
  logic err_clr;
  logic [DATA_W-1:0] push_data;
  logic [DATA_W-1:0] top_data;
  logic empty;
  logic full;
  logic [CNT_W-1:0] count;
  logic overflow_err;
  logic underflow_err;
  modport master(output StackWr, StackRd, err_clr, push_data,
                 input top_data, empty, full, count, overflow_err, underflow_err);
  modport slave(input StackWr, StackRd, err_clr, push_data,
                output top_data, empty, full, count, overflow_err, underflow_err);
endinterface

// File: rtl/ras_regfile.sv
// ras_regfile: DEPTH x DATA_W storage, one synchronous write port and one combinational read port.
module ras_regfile #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 8,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/return_addr_stack.sv
// return_addr_stack: hardware return-address stack with occupancy tracking and sticky overflow/underflow flags.
module return_addr_stack
  import riscp_pkg::*;
#(
  parameter int DATA_W = RAS_DATA_W,
  parameter int DEPTH = RAS_DEPTH
) (
  input logic clk,
  input logic reset,
  return_addr_stack_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  logic [CNT_W-1:0] r_count;
  logic r_ovf;
  logic r_unf;
  logic w_empty;
  logic w_full;
  logic w_both;
  logic w_inc;
  logic w_dec;
  logic w_replace;
  logic w_we;
  logic [AW-1:0] w_waddr;
  logic [AW-1:0] w_raddr;
  logic [DATA_W-1:0] w_rdata;
  always_comb begin
    w_empty = r_count == '0;
    w_full = r_count == FULL_CNT;
    w_both = bus.StackWr & bus.StackRd;
    w_replace = w_both & !w_empty;
    // push+pop on an empty stack behaves as a plain push
    w_inc = (bus.StackWr & !bus.StackRd & !w_full) | (w_both & w_empty);
    w_dec = bus.StackRd & !bus.StackWr & !w_empty;
    w_we = w_inc | w_replace;
    w_waddr = AW'(w_replace ? r_count - 1'b1 : r_count);
    w_raddr = AW'(r_count - 1'b1);
  end
  ras_regfile #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_regfile (
    .clk(clk),
    .i_we(w_we),
    .i_waddr(w_waddr),
    .i_wdata(bus.push_data),
    .i_raddr(w_raddr),
    .o_rdata(w_rdata)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_count <= w_inc ? r_count + 1'b1 : w_dec ? r_count - 1'b1 : r_count;
      r_ovf <= (bus.StackWr & !bus.StackRd & w_full) | (r_ovf & !bus.err_clr);
      r_unf <= (bus.StackRd & !bus.StackWr & w_empty) | (r_unf & !bus.err_clr);
    end
  end
  assign bus.top_data = w_empty ? '0 : w_rdata;
  assign bus.empty = w_empty;
  assign bus.full = w_full;
  assign bus.count = r_count;
  assign bus.overflow_err = r_ovf;
  assign bus.underflow_err = r_unf;
endmodule
